// File: rtl/piece_step_controller.sv
// Active-piece sequencer: spawn check, key/gravity arbitration onto one collision port, lock, game over.
// Grant-to-chk_req 1 cycle; position updates on the chk_ack edge; chk_req/lock_req hold until their ack.
module piece_step_controller #(
  parameter int GRAVITY_TICKS = 25000000,
  parameter int SPAWN_X       = 15,
  parameter int SPAWN_Y       = 0,
  parameter int NUM_PIECES    = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_out,
  output logic       chk_req,
  output logic [7:0] chk_x,
  output logic [7:0] chk_y,
  output logic [2:0] chk_sel,
  input  logic       chk_ack,
  input  logic       chk_blocked,
  output logic       lock_req,
  input  logic       lock_done,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [2:0] sel,
  output logic       game_over
);

  typedef enum logic [2:0] {SPAWN_CHK, PLAY, CHECK, LOCK, OVER} state_t;

  localparam logic [7:0]  KEY_LEFT  = 8'h1C;
  localparam logic [7:0]  KEY_RIGHT = 8'h23;
  localparam logic [7:0]  KEY_DROP  = 8'h1B;
  localparam logic [7:0]  SX        = 8'(SPAWN_X);
  localparam logic [7:0]  SY        = 8'(SPAWN_Y);
  localparam logic [31:0] GRAV_LAST = 32'(GRAVITY_TICKS - 1);
  localparam logic [2:0]  SEL_LAST  = 3'(NUM_PIECES - 1);

  state_t      state, state_nxt;
  logic [31:0] grav_cnt, grav_cnt_nxt;
  logic        grav_pend, grav_pend_nxt;
  logic        key_vld, key_vld_nxt;
  logic        key_right, key_right_nxt;
  logic        chk_grav, chk_grav_nxt;
  logic        chk_req_nxt;
  logic [7:0]  chk_x_nxt, chk_y_nxt;
  logic [7:0]  x_nxt, y_nxt;
  logic [2:0]  sel_nxt;

  logic capture, key_lr, key_drop, grav_wrap;

  assign capture   = (state == PLAY) || (state == CHECK);
  assign key_lr    = ps2_key_pressed && ((ps2_out == KEY_LEFT) || (ps2_out == KEY_RIGHT));
  assign key_drop  = ps2_key_pressed && (ps2_out == KEY_DROP);
  assign grav_wrap = capture && (grav_cnt == GRAV_LAST);

  assign chk_sel   = sel;
  assign lock_req  = (state == LOCK);
  assign game_over = (state == OVER);

  always_comb begin
    state_nxt     = state;
    grav_cnt_nxt  = grav_cnt;
    grav_pend_nxt = grav_pend;
    key_vld_nxt   = key_vld;
    key_right_nxt = key_right;
    chk_grav_nxt  = chk_grav;
    chk_req_nxt   = chk_req;
    chk_x_nxt     = chk_x;
    chk_y_nxt     = chk_y;
    x_nxt         = x;
    y_nxt         = y;
    sel_nxt       = sel;

    if (capture) begin
      grav_cnt_nxt = grav_wrap ? '0 : grav_cnt + 32'd1;
      if (key_lr) begin
        key_vld_nxt   = 1'b1;
        key_right_nxt = (ps2_out == KEY_RIGHT);
      end
      if (grav_wrap || key_drop) grav_pend_nxt = 1'b1;
    end

    case (state)
      SPAWN_CHK: begin
        if (!chk_req) begin
          chk_req_nxt = 1'b1;
        end else if (chk_ack) begin
          chk_req_nxt = 1'b0;
          state_nxt   = chk_blocked ? OVER : PLAY;
        end
      end
      PLAY: begin
        // A strobe landing on the grant cycle survives the clear and waits for the next grant.
        if (key_vld) begin
          key_vld_nxt  = key_lr;
          chk_x_nxt    = key_right ? x + 8'd1 : x - 8'd1;
          chk_y_nxt    = y;
          chk_grav_nxt = 1'b0;
          chk_req_nxt  = 1'b1;
          state_nxt    = CHECK;
        end else if (grav_pend) begin
          grav_pend_nxt = grav_wrap || key_drop;
          chk_x_nxt     = x;
          chk_y_nxt     = y + 8'd1;
          chk_grav_nxt  = 1'b1;
          chk_req_nxt   = 1'b1;
          state_nxt     = CHECK;
        end
      end
      CHECK: begin
        if (chk_ack) begin
          chk_req_nxt = 1'b0;
          if (!chk_blocked) begin
            x_nxt     = chk_x;
            y_nxt     = chk_y;
            state_nxt = PLAY;
          end else begin
            state_nxt = chk_grav ? LOCK : PLAY;
          end
        end
      end
      LOCK: begin
        if (lock_done) begin
          sel_nxt       = (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
          x_nxt         = SX;
          y_nxt         = SY;
          chk_x_nxt     = SX;
          chk_y_nxt     = SY;
          grav_cnt_nxt  = '0;
          key_vld_nxt   = 1'b0;
          grav_pend_nxt = 1'b0;
          state_nxt     = SPAWN_CHK;
        end
      end
      OVER: begin
      end
      default: state_nxt = SPAWN_CHK;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= SPAWN_CHK;
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
      key_vld   <= 1'b0;
      key_right <= 1'b0;
      chk_grav  <= 1'b0;
      chk_req   <= 1'b0;
      chk_x     <= SX;
      chk_y     <= SY;
      x         <= SX;
      y         <= SY;
      sel       <= 3'd0;
    end else begin
      state     <= state_nxt;
      grav_cnt  <= grav_cnt_nxt;
      grav_pend <= grav_pend_nxt;
      key_vld   <= key_vld_nxt;
      key_right <= key_right_nxt;
      chk_grav  <= chk_grav_nxt;
      chk_req   <= chk_req_nxt;
      chk_x     <= chk_x_nxt;
      chk_y     <= chk_y_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      sel       <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_piece_step_controller.sv
// Bench for piece_step_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_piece_step_controller;

  localparam int GT = 8;
  localparam int NP = 5;

  localparam int PH_SPAWN = 0;
  localparam int PH_PLAY  = 1;
  localparam int PH_CHECK = 2;
  localparam int PH_LOCK  = 3;
  localparam int PH_OVER  = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;
  logic       chk_req;
  logic [7:0] chk_x, chk_y;
  logic [2:0] chk_sel;
  logic       chk_ack, chk_blocked;
  logic       lock_req, lock_done;
  logic [7:0] x, y;
  logic [2:0] sel;
  logic       game_over;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  piece_step_controller #(
    .GRAVITY_TICKS(GT), .SPAWN_X(15), .SPAWN_Y(0), .NUM_PIECES(NP)
  ) dut (
    .clock(clock), .reset(reset),
    .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
    .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_sel(chk_sel),
    .chk_ack(chk_ack), .chk_blocked(chk_blocked),
    .lock_req(lock_req), .lock_done(lock_done),
    .x(x), .y(y), .sel(sel), .game_over(game_over)
  );

  // Behavioural model: the pending key is a queue of signed deltas, gravity a flag.
  int         m_phase;
  logic [7:0] m_x, m_y, m_cx, m_cy;
  logic [2:0] m_sel;
  bit         m_req, m_grav, m_is_grav;
  int         m_cnt;
  int         m_keys[$];

  task automatic model_step(input bit rst, input bit kp, input logic [7:0] code,
                            input bit ack, input bit blk, input bit done);
    bit live;
    bit tick;
    if (rst) begin
      m_phase = PH_SPAWN; m_x = 8'd15; m_y = 8'd0; m_sel = 3'd0; m_req = 1'b0;
      m_cx = 8'd15; m_cy = 8'd0; m_cnt = 0; m_grav = 1'b0; m_is_grav = 1'b0;
      m_keys.delete();
      return;
    end
    live = (m_phase == PH_PLAY) || (m_phase == PH_CHECK);
    tick = live && (((m_cnt + 1) % GT) == 0);
    case (m_phase)
      PH_SPAWN: begin
        if (!m_req) m_req = 1'b1;
        else if (ack) begin
          m_req = 1'b0;
          m_phase = blk ? PH_OVER : PH_PLAY;
        end
      end
      PH_PLAY: begin
        if (m_keys.size() != 0) begin
          m_cx = 8'(int'(m_x) + m_keys[0]); m_cy = m_y; m_is_grav = 1'b0;
          m_keys.delete(); m_req = 1'b1; m_phase = PH_CHECK;
        end else if (m_grav) begin
          m_cx = m_x; m_cy = 8'(int'(m_y) + 1); m_is_grav = 1'b1;
          m_grav = 1'b0; m_req = 1'b1; m_phase = PH_CHECK;
        end
      end
      PH_CHECK: begin
        if (ack) begin
          m_req = 1'b0;
          if (!blk) begin m_x = m_cx; m_y = m_cy; m_phase = PH_PLAY; end
          else m_phase = m_is_grav ? PH_LOCK : PH_PLAY;
        end
      end
      PH_LOCK: begin
        if (done) begin
          m_sel = 3'((int'(m_sel) + 1) % NP);
          m_x = 8'd15; m_y = 8'd0; m_cx = 8'd15; m_cy = 8'd0;
          m_cnt = 0; m_keys.delete(); m_grav = 1'b0; m_phase = PH_SPAWN;
        end
      end
      default: begin
      end
    endcase
    if (live) begin
      m_cnt = (m_cnt + 1) % GT;
      if (kp && code == 8'h1C) begin m_keys.delete(); m_keys.push_back(-1); end
      if (kp && code == 8'h23) begin m_keys.delete(); m_keys.push_back(1); end
      if (tick || (kp && code == 8'h1B)) m_grav = 1'b1;
    end
  endtask

  task automatic step(input bit rst, input bit kp, input logic [7:0] code,
                      input bit ack, input bit blk, input bit done);
    reset = rst; ps2_key_pressed = kp; ps2_out = code;
    chk_ack = ack; chk_blocked = blk; lock_done = done;
    @(posedge clock);
    model_step(rst, kp, code, ack, blk, done);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  // Checker stand-in: waits for chk_req, answers on its second cycle.
  task automatic serve(input bit blk, input int limit, output bit ok,
                       output logic [7:0] cx, output logic [7:0] cy);
    int n = 0;
    ok = 1'b0; cx = 8'h00; cy = 8'h00;
    while (chk_req !== 1'b1 && n < limit) begin idle(); n++; end
    if (chk_req === 1'b1) begin
      ok = 1'b1; cx = chk_x; cy = chk_y;
      idle();
      step(1'b0, 1'b0, 8'h00, 1'b1, blk, 1'b0);
    end
  endtask

  task automatic finish_lock(input int limit, output bit ok);
    int n = 0;
    while (lock_req !== 1'b1 && n < limit) begin idle(); n++; end
    ok = (lock_req === 1'b1);
    if (ok) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    vectors++;
    if ({chk_req, lock_req, game_over, x, y, sel} !== {3'b000, 8'd15, 8'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_state got req=%b lock=%b go=%b x=%0d y=%0d sel=%0d want 0 0 0 15 0 0",
               chk_req, lock_req, game_over, x, y, sel);
    end
    idle();
    vectors++;
    if ({chk_req, chk_x, chk_y, chk_sel} !== {1'b1, 8'd15, 8'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL spawn_req got req=%b cx=%0d cy=%0d cs=%0d want 1 15 0 0", chk_req, chk_x, chk_y, chk_sel);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({chk_req, lock_req, game_over, x, y, sel} !== {3'b000, 8'd15, 8'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL spawn_clear got req=%b lock=%b go=%b x=%0d y=%0d sel=%0d want 0 0 0 15 0 0",
               chk_req, lock_req, game_over, x, y, sel);
    end
  endtask

  task automatic test_gravity();
    int age = 0;
    int changes = 0;
    int last = -1;
    logic [7:0] prev_y;
    start();
    prev_y = y;
    for (int c = 1; c <= 60; c++) begin
      age = (chk_req === 1'b1) ? age + 1 : 0;
      step(1'b0, 1'b0, 8'h00, age == 2, 1'b0, 1'b0);
      if (y !== prev_y) begin
        changes++;
        vectors++;
        if (y !== prev_y + 8'd1 || x !== 8'd15) begin
          miscompares++;
          $display("FAIL grav_step got x=%0d y=%0d want x=15 y=%0d", x, y, prev_y + 8'd1);
        end
        if (last >= 0) begin
          vectors++;
          if (c - last != GT) begin
            miscompares++;
            $display("FAIL grav_period got %0d cycles want %0d", c - last, GT);
          end
        end
        last = c;
        prev_y = y;
      end
    end
    vectors++;
    if (changes != 7 || y !== 8'd7) begin
      miscompares++;
      $display("FAIL grav_count got steps=%0d y=%0d want 7 7", changes, y);
    end
  endtask

  task automatic test_key_move();
    start();
    step(1'b0, 1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
    idle();
    vectors++;
    if ({chk_req, chk_x, chk_y} !== {1'b1, 8'd16, 8'd0}) begin
      miscompares++;
      $display("FAIL right_cand got req=%b cx=%0d cy=%0d want 1 16 0", chk_req, chk_x, chk_y);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({chk_req, x, y} !== {1'b0, 8'd16, 8'd0}) begin
      miscompares++;
      $display("FAIL right_move got req=%b x=%0d y=%0d want 0 16 0", chk_req, x, y);
    end
    step(1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    idle();
    vectors++;
    if ({chk_req, chk_x, chk_y} !== {1'b1, 8'd15, 8'd0}) begin
      miscompares++;
      $display("FAIL left_cand got req=%b cx=%0d cy=%0d want 1 15 0", chk_req, chk_x, chk_y);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    vectors++;
    if ({chk_req, lock_req, x} !== {2'b00, 8'd16}) begin
      miscompares++;
      $display("FAIL left_blocked got req=%b lock=%b x=%0d want 0 0 16", chk_req, lock_req, x);
    end
    step(1'b0, 1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
    idle();
    vectors++;
    if ({chk_req, chk_x} !== {1'b1, 8'd17}) begin
      miscompares++;
      $display("FAIL replay_after_block got req=%b cx=%0d want 1 17", chk_req, chk_x);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_key_and_gravity();
    bit ok;
    logic [7:0] cx, cy;
    start();
    for (int i = 0; i < GT - 1; i++) idle();
    step(1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    serve(1'b0, 10, ok, cx, cy);
    vectors++;
    if (!ok || cx !== 8'd14 || cy !== 8'd0) begin
      miscompares++;
      $display("FAIL coinc_first got ok=%0b cx=%0d cy=%0d want 1 14 0", ok, cx, cy);
    end
    serve(1'b0, 10, ok, cx, cy);
    vectors++;
    if (!ok || cx !== 8'd14 || cy !== 8'd1 || x !== 8'd14 || y !== 8'd1) begin
      miscompares++;
      $display("FAIL coinc_second got ok=%0b cx=%0d cy=%0d x=%0d y=%0d want 1 14 1 14 1", ok, cx, cy, x, y);
    end
  endtask

  task automatic test_wrap();
    bit saw = 1'b0;
    bit hit = 1'b0;
    int age = 0;
    start();
    for (int c = 0; c < 200 && !hit; c++) begin
      if (chk_req === 1'b1 && chk_x === 8'hFF && x === 8'h00) saw = 1'b1;
      age = (chk_req === 1'b1) ? age + 1 : 0;
      step(1'b0, 1'b1, 8'h1C, age == 2, 1'b0, 1'b0);
      if (x === 8'hFF) hit = 1'b1;
    end
    vectors++;
    if (!saw || x !== 8'hFF || y !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap_left got seen=%0b x=%0d y=%0d want 1 255 0", saw, x, y);
    end
  endtask

  task automatic test_lock_over();
    bit ok;
    logic [7:0] cx, cy;
    int bad = 0;
    start();
    for (int p = 0; p < 4; p++) begin
      serve(1'b1, 40, ok, cx, cy);
      vectors++;
      if (!ok || cx !== 8'd15 || cy !== 8'd1) begin
        miscompares++;
        $display("FAIL lock_cand[%0d] got ok=%0b cx=%0d cy=%0d want 1 15 1", p, ok, cx, cy);
      end
      finish_lock(10, ok);
      serve(1'b0, 10, ok, cx, cy);
      vectors++;
      if (!ok || cx !== 8'd15 || cy !== 8'd0 || sel !== 3'(p + 1)) begin
        miscompares++;
        $display("FAIL respawn[%0d] got ok=%0b cx=%0d cy=%0d sel=%0d want 1 15 0 %0d", p, ok, cx, cy, sel, p + 1);
      end
    end
    for (int s = 0; s < 20; s++) serve(1'b0, 40, ok, cx, cy);
    vectors++;
    if (y !== 8'd20 || sel !== 3'd4) begin
      miscompares++;
      $display("FAIL drop_to_20 got y=%0d sel=%0d want 20 4", y, sel);
    end
    serve(1'b1, 40, ok, cx, cy);
    vectors++;
    if (!ok || cy !== 8'd21 || lock_req !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_at_20 got ok=%0b cy=%0d lock=%b want 1 21 1", ok, cy, lock_req);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({lock_req, sel, x, y} !== {1'b0, 3'd0, 8'd15, 8'd0}) begin
      miscompares++;
      $display("FAIL lock_done got lock=%b sel=%0d x=%0d y=%0d want 0 0 15 0", lock_req, sel, x, y);
    end
    idle();
    vectors++;
    if ({chk_req, chk_x, chk_y, chk_sel} !== {1'b1, 8'd15, 8'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL spawn_after_lock got req=%b cx=%0d cy=%0d cs=%0d want 1 15 0 0", chk_req, chk_x, chk_y, chk_sel);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (game_over !== 1'b1 || chk_req !== 1'b0) begin
      miscompares++;
      $display("FAIL game_over got go=%b req=%b want 1 0", game_over, chk_req);
    end
    for (int c = 0; c < 100; c++) begin
      step(1'b0, 1'b1, (c % 2 == 0) ? 8'h23 : 8'h1B, 1'b1, c[0], c[1]);
      if (chk_req !== 1'b0 || lock_req !== 1'b0 || game_over !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL over_quiet got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid_lock();
    bit ok;
    logic [7:0] cx, cy;
    start();
    serve(1'b1, 40, ok, cx, cy);
    finish_lock(10, ok);
    serve(1'b0, 10, ok, cx, cy);
    serve(1'b1, 40, ok, cx, cy);
    vectors++;
    if (lock_req !== 1'b1 || sel !== 3'd1) begin
      miscompares++;
      $display("FAIL pre_reset_lock got lock=%b sel=%0d want 1 1", lock_req, sel);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({lock_req, chk_req, sel, x, y} !== {2'b00, 3'd0, 8'd15, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_in_lock got lock=%b req=%b sel=%0d x=%0d y=%0d want 0 0 0 15 0",
               lock_req, chk_req, sel, x, y);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    vectors++;
    if ({chk_req, lock_req, game_over, sel} !== {3'b100, 3'd0}) begin
      miscompares++;
      $display("FAIL late_strobes got req=%b lock=%b go=%b sel=%0d want 1 0 0 0", chk_req, lock_req, game_over, sel);
    end
  endtask

  task automatic test_random();
    bit rst, kp, ack, blk, done;
    logic [7:0] code;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom_range(0, 399) == 0);
      kp   = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       code = 8'h1C;
        1:       code = 8'h23;
        2:       code = 8'h1B;
        default: code = 8'($urandom_range(0, 255));
      endcase
      ack  = ($urandom_range(0, 2) == 0);
      blk  = ($urandom_range(0, 4) == 0);
      done = ($urandom_range(0, 3) == 0);
      step(rst, kp, code, ack, blk, done);
      vectors++;
      if ({chk_req, chk_sel, lock_req, game_over, x, y, sel} !==
          {m_req, m_sel, m_phase == PH_LOCK, m_phase == PH_OVER, m_x, m_y, m_sel}) begin
        miscompares++;
        $display("FAIL random[%0d] got req=%b cs=%0d lock=%b go=%b x=%0d y=%0d sel=%0d want %b %0d %b %b %0d %0d %0d",
                 c, chk_req, chk_sel, lock_req, game_over, x, y, sel,
                 m_req, m_sel, m_phase == PH_LOCK, m_phase == PH_OVER, m_x, m_y, m_sel);
      end
      if (m_req) begin
        vectors++;
        if ({chk_x, chk_y} !== {m_cx, m_cy}) begin
          miscompares++;
          $display("FAIL random_cand[%0d] got cx=%0d cy=%0d want %0d %0d", c, chk_x, chk_y, m_cx, m_cy);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "simulation timeout");
  end

  initial begin
    test_reset();
    test_gravity();
    test_key_move();
    test_key_and_gravity();
    test_wrap();
    test_lock_over();
    test_reset_mid_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
